// File: rtl/linear_weight_server.sv
// Weight-fetch responder: serves one request at a time from an internal weight memory
// and accepts loader writes while idle. Optional next-address prefetch: WEIGHT_PREFETCH_EN.
module linear_weight_server #(
   parameter int WIDTH        = 16,
   parameter int IN_FEATURES  = 64,
   parameter int OUT_FEATURES = 128,
   parameter int READ_LATENCY = 2,
   localparam int DEPTH       = IN_FEATURES * OUT_FEATURES,
   localparam int ADDR_W      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              weight_req,
   input  logic [ADDR_W-1:0] weight_addr,
   output logic [WIDTH-1:0]  weight_data,
   output logic              weight_valid,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              wr_ready,
   output logic              addr_err,
   output logic [31:0]       req_count
);

   localparam int CNT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
   localparam int CNT_LOAD = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

   logic [WIDTH-1:0]  mem [DEPTH];

   state_t            state_r;
   state_t            state_nxt_s;
   logic [ADDR_W-1:0] addr_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              weight_valid_r;
   logic [WIDTH-1:0]  weight_data_r;
   logic              wr_ready_r;
   logic              addr_err_r;
   logic [31:0]       req_count_r;

   logic              accept_s;
   logic              accept_hit_s;
   logic              do_write_s;
   logic              resp_load_s;
   logic              rd_ok_s;
   logic [WIDTH-1:0]  rd_word_s;
   logic [WIDTH-1:0]  resp_data_s;
   logic              wr_ok_s;
   logic              rq_ok_s;
   logic              ar_ok_s;
   logic              pf_hit_s;
   logic              pf_wait_s;
   logic [WIDTH-1:0]  pf_data_s;

   // Range checks only exist when the address space is not a full power of two.
   if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      assign wr_ok_s = 1'b1;
      assign rq_ok_s = 1'b1;
      assign ar_ok_s = 1'b1;
   end else begin : g_part_range
      localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
      assign wr_ok_s = (wr_addr < LIMIT);
      assign rq_ok_s = (weight_addr < LIMIT);
      assign ar_ok_s = (addr_r < LIMIT);
   end

   // Next-state decode, write/accept strobes and the response word.
   always_comb begin
      state_nxt_s  = state_r;
      accept_s     = 1'b0;
      accept_hit_s = 1'b0;
      do_write_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (wr_en) begin
               do_write_s = 1'b1;
            end else if (weight_req && !pf_wait_s) begin
               accept_s = 1'b1;
               if (pf_hit_s) begin
                  accept_hit_s = 1'b1;
                  state_nxt_s  = RESP;
               end else if (READ_LATENCY == 1) begin
                  state_nxt_s = RESP;
               end else begin
                  state_nxt_s = READ;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         READ: begin
            if (cnt_r == '0) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = READ;
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase

      resp_load_s = (state_r != RESP) && (state_nxt_s == RESP);

      if (state_r == IDLE) begin
         rd_ok_s   = rq_ok_s;
         rd_word_s = mem[weight_addr];
      end else begin
         rd_ok_s   = ar_ok_s;
         rd_word_s = mem[addr_r];
      end

      if (accept_hit_s) begin
         resp_data_s = pf_data_s;
      end else if (rd_ok_s) begin
         resp_data_s = rd_word_s;
      end else begin
         resp_data_s = {WIDTH{1'b0}};
      end
   end

   // Control state, latency counter, response outputs and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         addr_r         <= '0;
         cnt_r          <= '0;
         weight_valid_r <= 1'b0;
         weight_data_r  <= '0;
         wr_ready_r     <= 1'b1;
         addr_err_r     <= 1'b0;
         req_count_r    <= 32'd0;
      end else begin
         state_r        <= state_nxt_s;
         weight_valid_r <= resp_load_s;
         wr_ready_r     <= (state_nxt_s == IDLE);
         if (accept_s) begin
            addr_r <= weight_addr;
            cnt_r  <= CNT_W'(CNT_LOAD);
         end else if ((state_r == READ) && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
         end
         if (resp_load_s) begin
            weight_data_r <= resp_data_s;
            if (req_count_r != 32'hFFFF_FFFF) begin
               req_count_r <= req_count_r + 32'd1;
            end
         end
         if ((accept_s && !rq_ok_s) || (do_write_s && !wr_ok_s)) begin
            addr_err_r <= 1'b1;
         end
      end
   end

   // Loader write port; memory contents survive reset.
   always_ff @(posedge clk) begin
      if (do_write_s && wr_ok_s) begin
         mem[wr_addr] <= wr_data;
      end
   end

`ifdef WEIGHT_PREFETCH_EN
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic              pf_valid_r;
   logic              pf_busy_r;
   logic [ADDR_W-1:0] pf_tag_r;
   logic [WIDTH-1:0]  pf_data_r;
   logic [CNT_W-1:0]  pf_cnt_r;
   logic [ADDR_W-1:0] pf_next_s;

   assign pf_next_s = (weight_addr == LAST) ? {ADDR_W{1'b0}} : weight_addr + ADDR_W'(1);
   assign pf_hit_s  = pf_valid_r && (pf_tag_r == weight_addr);
   assign pf_wait_s = pf_busy_r && (pf_tag_r == weight_addr);
   assign pf_data_s = pf_data_r;

   // One-entry speculative buffer for the address following each accepted demand read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pf_valid_r <= 1'b0;
         pf_busy_r  <= 1'b0;
         pf_tag_r   <= '0;
         pf_data_r  <= '0;
         pf_cnt_r   <= '0;
      end else if (do_write_s && (wr_addr == pf_tag_r) && (pf_valid_r || pf_busy_r)) begin
         pf_valid_r <= 1'b0;
         pf_busy_r  <= 1'b0;
      end else if (accept_s) begin
         pf_valid_r <= 1'b0;
         pf_busy_r  <= 1'b0;
         if (rq_ok_s) begin
            pf_tag_r <= pf_next_s;
            if (READ_LATENCY == 1) begin
               pf_data_r  <= mem[pf_next_s];
               pf_valid_r <= 1'b1;
            end else begin
               pf_busy_r <= 1'b1;
               pf_cnt_r  <= CNT_W'(CNT_LOAD);
            end
         end
      end else if (pf_busy_r) begin
         if (pf_cnt_r == '0) begin
            pf_data_r  <= mem[pf_tag_r];
            pf_valid_r <= 1'b1;
            pf_busy_r  <= 1'b0;
         end else begin
            pf_cnt_r <= pf_cnt_r - CNT_W'(1);
         end
      end
   end
`else
   assign pf_hit_s  = 1'b0;
   assign pf_wait_s = 1'b0;
   assign pf_data_s = {WIDTH{1'b0}};
`endif

   assign weight_valid = weight_valid_r;
   assign weight_data  = weight_data_r;
   assign wr_ready     = wr_ready_r;
   assign addr_err     = addr_err_r;
   assign req_count    = req_count_r;

endmodule

// File: tb/tb_linear_weight_server.sv
// Scoreboard bench for linear_weight_server (DEPTH=100 so out-of-range addresses exist).
// Expected hit latency follows WEIGHT_PREFETCH_EN.
module tb_linear_weight_server;

   localparam int WIDTH  = 16;
   localparam int IN_F   = 10;
   localparam int OUT_F  = 10;
   localparam int RL     = 2;
   localparam int DEPTH  = IN_F * OUT_F;
   localparam int ADDR_W = $clog2(DEPTH);
`ifdef WEIGHT_PREFETCH_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = RL;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              weight_req = 1'b0;
   logic [ADDR_W-1:0] weight_addr = '0;
   logic [WIDTH-1:0]  weight_data;
   logic              weight_valid;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [WIDTH-1:0]  wr_data = '0;
   logic              wr_ready;
   logic              addr_err;
   logic [31:0]       req_count;

   linear_weight_server #(
      .WIDTH(WIDTH), .IN_FEATURES(IN_F), .OUT_FEATURES(OUT_F), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .weight_req(weight_req), .weight_addr(weight_addr),
      .weight_data(weight_data), .weight_valid(weight_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .addr_err(addr_err), .req_count(req_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               due;
      string            name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Monitor: every response must match the oldest outstanding expectation in data and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (weight_valid) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid: got data %h at cycle %0d, no response expected",
                     weight_data, cyc);
         end else begin
            e = sb.pop_front();
            if (weight_data !== e.data || cyc != e.due) begin
               fails++;
               $display("FAIL %s: got data %h at cycle %0d, expected %h at cycle %0d",
                        e.name, weight_data, cyc, e.data, e.due);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_valid"}, 32'(weight_valid), 32'd0);
      check({name, "_data"}, 32'(weight_data), 32'd0);
      check({name, "_wr_ready"}, 32'(wr_ready), 32'd1);
      check({name, "_addr_err"}, 32'(addr_err), 32'd0);
      check({name, "_count"}, req_count, 32'd0);
   endtask

   task automatic wr(input int a, input logic [WIDTH-1:0] d);
      int k = 0;
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_data = d;
      while (!wr_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!wr_ready) begin
         tests++;
         fails++;
         $display("FAIL write_timeout: wr_ready stayed 0, expected 1 within 20 cycles");
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      @(negedge clk);
      while (!weight_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!weight_valid) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: weight_valid stayed 0, expected 1 within 20 cycles", name);
      end
      weight_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd(input int a, input logic [WIDTH-1:0] d, input int lat, input string name);
      weight_req  = 1'b1;
      weight_addr = ADDR_W'(a);
      sb.push_back('{data: d, due: cyc + lat, name: name});
      wait_valid(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      wr(5, 16'h0123);
      rd(5, 16'h0123, RL, "basic_a5");
      check("count_basic", req_count, 32'd1);

      for (int i = 0; i < 64; i++) wr(i, WIDTH'(i));
      for (int i = 0; i < 64; i++) rd(i, WIDTH'(i), (i == 0) ? RL : HIT_LAT, "seq_read");
      check("count_seq", req_count, 32'd65);

      // Write and request in the same idle cycle: write first, request one cycle later.
      wr_en       = 1'b1;
      wr_addr     = ADDR_W'(7);
      wr_data     = 16'h7FFF;
      weight_req  = 1'b1;
      weight_addr = ADDR_W'(7);
      sb.push_back('{data: 16'h7FFF, due: cyc + 1 + RL, name: "wr_then_req"});
      @(negedge clk);
      wr_en = 1'b0;
      wait_valid("wr_then_req");

      rd(120, 16'h0000, RL, "oor_read");
      check("addr_err_set", 32'(addr_err), 32'd1);
      rd(3, 16'h0003, RL, "after_oor");
      check("addr_err_sticky", 32'(addr_err), 32'd1);
      check("count_oor", req_count, 32'd68);

      // Reset while the read for addr 5 is in flight.
      wr(5, 16'h0123);
      weight_req  = 1'b1;
      weight_addr = ADDR_W'(5);
      @(negedge clk);
      check("wr_ready_in_read", 32'(wr_ready), 32'd0);
      rst_n      = 1'b0;
      weight_req = 1'b0;
      @(negedge clk);
      check_reset_state("mid_read_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd(5, 16'h0123, RL, "retained_a5");

      // A write to the prefetched address must not return the stale word.
      rd(10, 16'h000A, RL, "pf_seed_a10");
      wr(11, 16'h8001);
      rd(11, 16'h8001, RL, "pf_invalidated_a11");

      wr(99, 16'h1111);
      wr(0, 16'h2222);
      rd(99, 16'h1111, RL, "last_addr");
      rd(0, 16'h2222, HIT_LAT, "wrap_to_zero");
      check("count_final", req_count, 32'd5);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/linear_weight_server.md
# linear_weight_server

Responder for the fully-connected layer's external weight-fetch interface. Serves one `weight_req`/`weight_addr` transaction at a time from an internal synchronous weight memory and returns exactly one `weight_valid` pulse with `weight_data`. A write port lets the weight loader fill the memory before inference. It sits between the weight loader and the final linear layer in the classifier head.

## Interface

Parameters:

- `WIDTH`, 16: weight word width, signed Q(WIDTH-FRAC).FRAC; passed through unmodified.
- `IN_FEATURES`, 64: inputs per output neuron.
- `OUT_FEATURES`, 128: output neurons.
- `READ_LATENCY`, 2: memory read pipeline depth in cycles, ≥1.
- `DEPTH` (derived): IN_FEATURES*OUT_FEATURES.
- `ADDR_W` (derived): $clog2(DEPTH).

Ports:

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `weight_req`  in  1  read request from the linear layer.
- `weight_addr`  in  ADDR_W  read address, row-major (out_idx*IN_FEATURES+in_idx).
- `weight_data`  out  WIDTH  signed read data; valid only while `weight_valid`=1.
- `weight_valid`  out  1  one-cycle pulse per accepted request.
- `wr_en`  in  1  loader write strobe.
- `wr_addr`  in  ADDR_W  loader write address.
- `wr_data`  in  WIDTH  loader write data.
- `wr_ready`  out  1  high iff FSM is in IDLE; a write occurs when `wr_en`&&`wr_ready`.
- `addr_err`  out  1  sticky: a request or write used address ≥ DEPTH.
- `req_count`  out  32  number of responses issued, saturating at 2^32-1.

## Operation

- FSM states are IDLE, READ, and RESP.
- IDLE:
  - If `wr_en`, perform the write; a write has priority and any pending `weight_req` is accepted the next cycle, since the requester holds it.
  - Else if `weight_req`, capture `weight_addr` and go to READ. Under prefetch hit, go directly to RESP.
- READ: count READ_LATENCY-1 cycles, then go to RESP.
- RESP:
  - Drive `weight_valid`=1 and `weight_data`=mem[addr].
  - Increment `req_count`.
  - Return to IDLE.
- Requester rule: deassert `weight_req` in the cycle after `weight_valid`. The server does not re-accept until IDLE, which is the cycle after RESP.
- Read address ≥ DEPTH: respond normally with `weight_data`=0 and set `addr_err`.
- Write address ≥ DEPTH: the write is dropped and `addr_err` is set.
- `addr_err` clears only on reset.
- No arithmetic on data; bit-exact pass-through of the stored signed word.

## Timing

- Reset values:
  - `weight_valid`=0, `weight_data`=0.
  - `wr_ready`=1 (IDLE).
  - `addr_err`=0, `req_count`=0.
  - Prefetch buffer invalid.
- Memory contents are not reset.
- Miss latency: request accepted in cycle c, `weight_valid` in cycle c+READ_LATENCY.
- `weight_data` is held at its last value when `weight_valid`=0.
- Reset asserted mid-READ/RESP: the transaction is abandoned, no `weight_valid` is issued, and the FSM is in IDLE on release.
- `wr_ready` is 0 in READ and RESP. The loader must hold `wr_en`/`wr_addr`/`wr_data` until `wr_ready`.

## Configuration

- `WEIGHT_PREFETCH_EN` defined:
  - A second read port speculatively reads (addr+1) mod DEPTH when a demand read is accepted. Address DEPTH-1 wraps to 0.
  - The result and tag are kept in a one-entry buffer.
  - Hit (tag match, buffer valid): `weight_valid` in cycle c+1.
  - Tag match while the prefetch is still in flight: wait for it; never slower than a miss.
  - A write to the tagged address invalidates the buffer, including an in-flight prefetch.
- `WEIGHT_PREFETCH_EN` not defined: no prefetch logic; every request takes miss latency.

## Test plan

- Write mem[5]=0x0123, then request addr 5 with READ_LATENCY=2 -> single `weight_valid` pulse 2 cycles after acceptance, `weight_data`=0x0123; `req_count`=1.
- Load mem[i]=i for i=0..63, then sequential requests 0..63 -> data equals address.
  - With `WEIGHT_PREFETCH_EN`: first response at +2, the remaining 63 at +1.
  - Without it: all at +2.
- `wr_en`(addr 7, 0x7FFF) and `weight_req`(addr 7) in the same IDLE cycle -> write performed first, request accepted next cycle, returns 0x7FFF.
- IN_FEATURES=3, OUT_FEATURES=3 (DEPTH=9, ADDR_W=4), request addr 12 -> `weight_valid` pulse with `weight_data`=0; `addr_err`=1, which stays 1 through later valid requests.
- Assert `rst_n`=0 during READ for addr 5 -> no `weight_valid`, all outputs at reset values. A subsequent request for addr 5 returns 0x0123 (memory retained).
- `WEIGHT_PREFETCH_EN`: serve addr 10 (buffer holds 11), write mem[11]=0x8001, request 11 -> 0x8001 at miss latency +2, not the stale prefetched value.
